// File: rtl/ahb_si_arbiter_slave_2.sv
// Round-robin AHB arbiter for slave interface 2: owns the one-hot address-phase
// grant and the data-phase owner vector, holding ownership across bursts and locks.
module ahb_si_arbiter_slave_2 #(
  parameter int CHANNEL_NUM = 3,
  parameter int IDX_W       = $clog2(CHANNEL_NUM)
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0]      hlock,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans_in,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst_in,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      hgrant,
  output logic [IDX_W-1:0]            hmaster,
  output logic [CHANNEL_NUM-1:0]      hsel_data,
  output logic                        hmastlock
);

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] B_INCR   = 3'b001;

  typedef enum logic [1:0] {ARB, BURST, INCR, LOCK} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             beats_left_q, beats_left_d;
  logic [CHANNEL_NUM-1:0] hgrant_q, hgrant_d;
  logic [IDX_W-1:0]       hmaster_q, hmaster_d;
  logic [CHANNEL_NUM-1:0] hsel_data_q, hsel_data_d;

  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       own_lock;
  logic       accepted, acc_nonseq, acc_seq, rearb, found;
  logic [3:0] load_val;
  int         cand;

  // Owner fields selected by the one-hot grant (OR-mux avoids out-of-range indexing).
  always_comb begin
    own_trans = '0;
    own_burst = '0;
    own_lock  = 1'b0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (hgrant_q[i]) begin
        own_trans = own_trans | htrans_in[i];
        own_burst = own_burst | hburst_in[i];
        own_lock  = own_lock  | hlock[i];
      end
    end
  end

  always_comb begin
    accepted   = hready && own_trans[1];
    acc_nonseq = accepted && (own_trans == T_NONSEQ);
    acc_seq    = accepted && (own_trans == T_SEQ);

    case (own_burst)
      3'd2, 3'd3: load_val = 4'd3;
      3'd4, 3'd5: load_val = 4'd7;
      3'd6, 3'd7: load_val = 4'd15;
      default:    load_val = 4'd0;
    endcase

    beats_left_d = beats_left_q;
    if (acc_nonseq)
      beats_left_d = load_val;
    else if (acc_seq && beats_left_q != 4'd0)
      beats_left_d = beats_left_q - 4'd1;

    state_d = state_q;
    if (hready) begin
      case (state_q)
        ARB: begin
          // Lock wins over burst so a locked burst stays in LOCK.
          if (own_lock && own_trans != T_IDLE)       state_d = LOCK;
          else if (acc_nonseq && load_val != 4'd0)   state_d = BURST;
          else if (acc_nonseq && own_burst == B_INCR) state_d = INCR;
        end
        BURST: if (acc_seq && beats_left_q == 4'd1)  state_d = ARB;
        INCR:  if (own_trans == T_IDLE || own_trans == T_NONSEQ) state_d = ARB;
        LOCK:  if (!own_lock && own_trans == T_IDLE) state_d = ARB;
        default: state_d = ARB;
      endcase
    end

    rearb = hready && (state_d == ARB);

    // Round-robin search from owner+1; no other requester leaves the grant parked.
    hgrant_d  = hgrant_q;
    hmaster_d = hmaster_q;
    found     = 1'b0;
    cand      = 0;
    if (rearb) begin
      for (int k = 1; k < CHANNEL_NUM; k++) begin
        cand = (int'(hmaster_q) + k) % CHANNEL_NUM;
        if (!found && hreq[cand]) begin
          found           = 1'b1;
          hgrant_d        = '0;
          hgrant_d[cand]  = 1'b1;
          hmaster_d       = IDX_W'(cand);
        end
      end
    end

    hsel_data_d = hready ? hgrant_q : hsel_data_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ARB;
      beats_left_q <= '0;
      hgrant_q     <= CHANNEL_NUM'(1);
      hmaster_q    <= '0;
      hsel_data_q  <= CHANNEL_NUM'(1);
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hsel_data_q  <= hsel_data_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hsel_data = hsel_data_q;
  assign hmastlock = own_lock && (own_trans != T_IDLE);

endmodule

// File: tb/tb_ahb_si_arbiter_slave_2.sv
// Directed bench for the slave-2 round-robin arbiter: handover, bursts, lock, reset.
module tb_ahb_si_arbiter_slave_2;

  localparam int N = 3;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [N-1:0]      hreq, hlock;
  logic [N-1:0][1:0] htrans_in;
  logic [N-1:0][2:0] hburst_in;
  logic              hready;
  logic [N-1:0]      hgrant, hsel_data;
  logic [1:0]        hmaster;
  logic              hmastlock;

  int checks = 0;
  int passes = 0;

  ahb_si_arbiter_slave_2 #(.CHANNEL_NUM(N)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .hreq(hreq), .hlock(hlock),
    .htrans_in(htrans_in), .hburst_in(hburst_in), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hsel_data(hsel_data), .hmastlock(hmastlock)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] t, input logic [2:0] b, input logic l);
    htrans_in[ch] = t;
    hburst_in[ch] = b;
    hlock[ch]     = l;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; hreq = '0; hlock = '0; htrans_in = '0; hburst_in = '0; hready = 1'b1;
    step(); step();
    HRESET = 1'b0;
    checks++;
    if ({hgrant, hmaster, hsel_data, hmastlock} !== {3'b001, 2'd0, 3'b001, 1'b0})
      $display("FAIL reset_state got g=%b m=%0d sel=%b lk=%b want g=001 m=0 sel=001 lk=0",
               hgrant, hmaster, hsel_data, hmastlock);
    else passes++;
    checks++;
    if (dut.beats_left_q !== 4'd0) $display("FAIL reset_beats got %0d want 0", dut.beats_left_q);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({hgrant, hmaster, hsel_data, hmastlock} !== {3'b001, 2'd0, 3'b001, 1'b0})
        $display("FAIL park_idle[%0d] got g=%b m=%0d sel=%b lk=%b want g=001 m=0 sel=001 lk=0",
                 i, hgrant, hmaster, hsel_data, hmastlock);
      else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] eg [3] = '{3'b010, 3'b100, 3'b010};
    logic [1:0] em [3] = '{2'd1, 2'd2, 2'd1};
    logic [2:0] es [3] = '{3'b001, 3'b010, 3'b100};
    hreq = 3'b110;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({hgrant, hmaster, hsel_data} !== {eg[i], em[i], es[i]})
        $display("FAIL rr[%0d] got g=%b m=%0d sel=%b want g=%b m=%0d sel=%b",
                 i, hgrant, hmaster, hsel_data, eg[i], em[i], es[i]);
      else passes++;
    end
  endtask

  task automatic test_fixed_burst();
    // ch1 owns; INCR4 with a two-cycle wait on the second beat
    hreq = 3'b111;
    set_ch(1, NONSEQ, INCR4, 1'b0);
    step();
    checks++;
    if ({hgrant, hsel_data, dut.beats_left_q} !== {3'b010, 3'b010, 4'd3})
      $display("FAIL burst_nonseq got g=%b sel=%b bl=%0d want g=010 sel=010 bl=3",
               hgrant, hsel_data, dut.beats_left_q);
    else passes++;
    set_ch(1, SEQ, INCR4, 1'b0);
    hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({hgrant, hsel_data, dut.beats_left_q} !== {3'b010, 3'b010, 4'd3})
        $display("FAIL burst_wait[%0d] got g=%b sel=%b bl=%0d want g=010 sel=010 bl=3",
                 i, hgrant, hsel_data, dut.beats_left_q);
      else passes++;
    end
    hready = 1'b1;
    step();
    checks++;
    if ({hgrant, dut.beats_left_q} !== {3'b010, 4'd2})
      $display("FAIL burst_beat2 got g=%b bl=%0d want g=010 bl=2", hgrant, dut.beats_left_q);
    else passes++;
    step();
    checks++;
    if ({hgrant, dut.beats_left_q} !== {3'b010, 4'd1})
      $display("FAIL burst_beat3 got g=%b bl=%0d want g=010 bl=1", hgrant, dut.beats_left_q);
    else passes++;
    step();
    checks++;
    if ({hgrant, hmaster, hsel_data, dut.beats_left_q} !== {3'b100, 2'd2, 3'b010, 4'd0})
      $display("FAIL burst_release got g=%b m=%0d sel=%b bl=%0d want g=100 m=2 sel=010 bl=0",
               hgrant, hmaster, hsel_data, dut.beats_left_q);
    else passes++;
    set_ch(1, IDLE, SINGLE, 1'b0);
  endtask

  task automatic test_lock();
    hreq = 3'b101;
    set_ch(2, NONSEQ, SINGLE, 1'b1);
    #1;
    checks++;
    if (hmastlock !== 1'b1) $display("FAIL lock_first got %b want 1", hmastlock);
    else passes++;
    step();
    checks++;
    if ({hgrant, hsel_data} !== {3'b100, 3'b100})
      $display("FAIL lock_hold1 got g=%b sel=%b want g=100 sel=100", hgrant, hsel_data);
    else passes++;
    checks++;
    if (hmastlock !== 1'b1) $display("FAIL lock_second got %b want 1", hmastlock);
    else passes++;
    step();
    checks++;
    if (hgrant !== 3'b100) $display("FAIL lock_hold2 got g=%b want 100", hgrant);
    else passes++;
    set_ch(2, IDLE, SINGLE, 1'b0);
    #1;
    checks++;
    if (hmastlock !== 1'b0) $display("FAIL lock_idle got %b want 0", hmastlock);
    else passes++;
    step();
    checks++;
    if ({hgrant, hmaster, hsel_data} !== {3'b001, 2'd0, 3'b100})
      $display("FAIL lock_release got g=%b m=%0d sel=%b want g=001 m=0 sel=100",
               hgrant, hmaster, hsel_data);
    else passes++;
  endtask

  task automatic test_incr_burst();
    logic [1:0] seq [4] = '{NONSEQ, SEQ, BUSY, SEQ};
    hreq = 3'b011;
    for (int i = 0; i < 4; i++) begin
      set_ch(0, seq[i], INCR, 1'b0);
      step();
      checks++;
      if (hgrant !== 3'b001) $display("FAIL incr_hold[%0d] got g=%b want 001", i, hgrant);
      else passes++;
    end
    set_ch(0, IDLE, INCR, 1'b0);
    step();
    checks++;
    if ({hgrant, hmaster, hsel_data} !== {3'b010, 2'd1, 3'b001})
      $display("FAIL incr_release got g=%b m=%0d sel=%b want g=010 m=1 sel=001",
               hgrant, hmaster, hsel_data);
    else passes++;
    set_ch(0, IDLE, SINGLE, 1'b0);
    hreq = 3'b010;
    step();
    checks++;
    if ({hgrant, hsel_data} !== {3'b010, 3'b010})
      $display("FAIL owner_only got g=%b sel=%b want g=010 sel=010", hgrant, hsel_data);
    else passes++;
    hreq = 3'b000;
    step();
    checks++;
    if ({hgrant, hmaster} !== {3'b010, 2'd1})
      $display("FAIL park_last got g=%b m=%0d want g=010 m=1", hgrant, hmaster);
    else passes++;
  endtask

  task automatic test_reset_mid_burst();
    hreq = 3'b100;
    step();
    checks++;
    if (hgrant !== 3'b100) $display("FAIL mid_setup got g=%b want 100", hgrant);
    else passes++;
    set_ch(2, NONSEQ, INCR8, 1'b0);
    step();
    set_ch(2, SEQ, INCR8, 1'b0);
    step();
    checks++;
    if ({hgrant, dut.beats_left_q} !== {3'b100, 4'd6})
      $display("FAIL mid_beats got g=%b bl=%0d want g=100 bl=6", hgrant, dut.beats_left_q);
    else passes++;
    HRESET = 1'b1;
    step();
    checks++;
    if ({hgrant, hmaster, hsel_data, hmastlock, dut.beats_left_q} !==
        {3'b001, 2'd0, 3'b001, 1'b0, 4'd0})
      $display("FAIL mid_reset got g=%b m=%0d sel=%b lk=%b bl=%0d want g=001 m=0 sel=001 lk=0 bl=0",
               hgrant, hmaster, hsel_data, hmastlock, dut.beats_left_q);
    else passes++;
    HRESET = 1'b0;
    step();
    checks++;
    if ({hgrant, hsel_data} !== {3'b100, 3'b001})
      $display("FAIL post_reset_arb got g=%b sel=%b want g=100 sel=001", hgrant, hsel_data);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_lock();
    test_incr_burst();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ahb_si_arbiter_slave_2.md
# ahb_si_arbiter_slave_2

Round-robin AHB arbiter for slave interface 2 of the generated interconnect. It sits directly upstream of the master-side payload multiplexer for that slave and owns the one-hot `hgrant` vector that drives the mux `sel` input. It also owns the registered data-phase owner vector that steers the return path. Grant ownership is held across fixed-length bursts, undefined-length INCR bursts and locked sequences. The grant only moves on an `hready`-qualified boundary.

## Interface
- `CHANNEL_NUM`, 3: number of requesting master channels (≥2); must equal the mux `CHANNEL_NUM`.
- `IDX_W`, `$clog2(CHANNEL_NUM)`: width of the encoded owner index.
- `HCLK`  in  1  bus clock; all state updates on the rising edge.
- `HRESET`  in  1  synchronous, active-high reset.
- `hreq`  in  CHANNEL_NUM  per-channel bus request.
- `hlock`  in  CHANNEL_NUM  per-channel locked-transfer request.
- `htrans_in`  in  CHANNEL_NUM×2  per-channel HTRANS (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- `hburst_in`  in  CHANNEL_NUM×3  per-channel HBURST.
- `hready`  in  1  slave HREADYOUT; 1 = the current data phase completes this cycle.
- `hgrant`  out  CHANNEL_NUM  one-hot address-phase owner; drives the mux `sel`.
- `hmaster`  out  IDX_W  encoded index of `hgrant`.
- `hsel_data`  out  CHANNEL_NUM  one-hot data-phase owner.
- `hmastlock`  out  1  the address phase in flight is locked.

## Operation
- `hgrant` is always exactly one-hot, including when no channel requests. With no requests the grant is parked on the last owner.
- Owner signals: `own_trans`, `own_burst` and `own_lock` are the `htrans_in`, `hburst_in` and `hlock` fields of the granted channel.
- An accepted beat is a cycle with `hready`=1 and `own_trans` equal to NONSEQ or SEQ.
- Burst counter `beats_left` (4 bits) is updated only on accepted beats:
  - NONSEQ with INCR4/WRAP4 loads 3; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15; SINGLE or INCR loads 0.
  - SEQ decrements the counter, saturating at 0.
- FSM states:
  - ARB: free to re-arbitrate.
  - BURST: fixed-length burst in progress.
  - INCR: undefined-length burst in progress.
  - LOCK: locked sequence in progress.
- FSM transitions, evaluated only when `hready`=1 (FSM holds when `hready`=0):
  - ARB → LOCK: `own_lock`=1 and `own_trans`≠IDLE.
  - ARB → BURST: an accepted NONSEQ loads a nonzero count.
  - ARB → INCR: accepted NONSEQ with INCR.
  - BURST → ARB: accepted SEQ takes `beats_left` from 1 to 0.
  - INCR → ARB: `own_trans` is IDLE or NONSEQ.
  - LOCK → ARB: `own_lock`=0 and `own_trans`=IDLE.
- Re-arbitration fires when `hready`=1 and the next state is ARB.
  - Winner: first requesting channel in round-robin order starting at owner+1 and wrapping modulo CHANNEL_NUM.
  - If only the owner requests, or no channel requests, the grant holds.
- `hsel_data` ← `hgrant` on every `hready`=1 edge; it holds while `hready`=0.
- `hmastlock` = `own_lock` AND `own_trans`≠IDLE, taken combinationally from the current grant.
- Lock takes precedence over burst: a locked burst stays in LOCK until the exit condition holds.

## Timing
- Reset (HRESET=1 at an edge):
  - `hgrant`=…001 (channel 0), `hmaster`=0, `hsel_data`=…001, `hmastlock`=0.
  - State ARB, `beats_left`=0.
- `hgrant` and `hmaster` are registered and change only on an edge where `hready`=1. The new owner drives its address phase in the following cycle.
- Minimum handover latency is 1 cycle: a request seen at edge N in state ARB with `hready`=1 is granted from N+1.
- `hsel_data` lags `hgrant` by exactly one `hready`-qualified edge.
- Wait states (`hready`=0) freeze `hgrant`, `hsel_data`, the FSM and `beats_left`.
- BUSY during a burst neither decrements the counter nor releases the grant.
- A reset asserted mid-burst or mid-lock overrides everything: the next cycle matches the reset values exactly.

## Test plan
- Reset, then `hreq`=000 for 5 cycles → `hgrant`=001, `hmaster`=0, `hmastlock`=0 throughout.
- Ch0 owner idle, `hreq`=110, `hready`=1 → `hgrant`=010 next cycle; `hreq` held → 100 on the following cycle, then 010 (round-robin wrap skips non-requester ch0).
- Ch1 issues NONSEQ INCR4 plus 3 SEQ with `hreq`=111, `hready` low on beat 2 for 2 cycles → `hgrant` stays 010 until the 4th beat is accepted, then moves to 100. `hsel_data` follows one `hready` edge later.
- Ch2 `hlock`=1 issuing SINGLE NONSEQ, NONSEQ, then IDLE with `hlock`=0, while ch0 requests → `hmastlock`=1 on both NONSEQs, grant held on 100, ch0 granted the cycle after the IDLE.
- Ch0 INCR burst (NONSEQ, SEQ, BUSY, SEQ, IDLE) with ch1 requesting → grant held through BUSY, switches to 010 after IDLE.
- HRESET asserted in the middle of an INCR8 burst on ch2 → next cycle `hgrant`=001, `hsel_data`=001, `beats_left`=0, state ARB.
